// File: rtl/pcpu_pkg.sv
// Shared pipeline constants and types: reset/handler PCs, bubble encoding,
// and the interrupt FSM state enum used by the fetch stage.
package pcpu_pkg;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] BUBBLE_INSTR   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_NORMAL     = 2'd0,
    ST_INT_PEND   = 2'd1,
    ST_IN_HANDLER = 2'd2
  } int_state_t;

  // 32-bit modulo increment; the PC is never realigned.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/if_id_stage_if.sv
// Bus bundle for the fetch stage: hazard controls, instruction-memory port,
// IF/ID outputs and interrupt signals. The stage uses the master modport.
interface if_id_stage_if;
  import pcpu_pkg::*;

  // Flow control: there is no valid/ready pair here. Decode back-pressures with
  // stall (hold everything), IF_flush replaces the next fetch with a bubble, and
  // Valid_id_o marks whether the IF/ID register holds a real instruction.
  logic        stall;
  logic        IF_flush;
  logic [31:0] redirect_pc_i;
  logic        int_req_i;
  logic        int_en_i;
  logic        eret_i;
  logic [31:0] imem_data_i;
  logic [31:0] imem_addr_o;
  logic [31:0] Instr_id_o;
  logic [31:0] PC_id_o;
  logic [31:0] NPC_id_o;
  logic        Valid_id_o;
  logic [31:0] epc_o;
  logic        int_ack_o;
  int_state_t  int_state;

  modport master (
    input  stall, IF_flush, redirect_pc_i, int_req_i, int_en_i, eret_i, imem_data_i,
    output imem_addr_o, Instr_id_o, PC_id_o, NPC_id_o, Valid_id_o, epc_o, int_ack_o,
           int_state
  );

  modport slave (
    output stall, IF_flush, redirect_pc_i, int_req_i, int_en_i, eret_i, imem_data_i,
    input  imem_addr_o, Instr_id_o, PC_id_o, NPC_id_o, Valid_id_o, epc_o, int_ack_o,
           int_state
  );
endinterface

// File: rtl/if_int_ctrl.sv
// Interrupt FSM for the fetch stage: decides when to take the handler redirect
// or the eret return, and holds the saved return PC and the ack pulse.
module if_int_ctrl
  import pcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        IF_flush,
  input  logic [31:0] redirect_pc,
  input  logic        int_req,
  input  logic        int_en,
  input  logic        eret,
  input  logic [31:0] pc,
  output logic        take_int,
  output logic        take_eret,
  output logic [31:0] epc,
  output logic        int_ack,
  output int_state_t  state
);
  int_state_t state_next;
  logic       req;

  assign req = int_req & int_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_NORMAL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_NORMAL:     if (req) state_next = stall ? ST_INT_PEND : ST_IN_HANDLER;
      ST_INT_PEND:   if (!req) state_next = ST_NORMAL;
                     else if (!stall) state_next = ST_IN_HANDLER;
      ST_IN_HANDLER: if (eret && !stall) state_next = ST_NORMAL;
      default:       state_next = ST_NORMAL;
    endcase
  end

  // A stalled stage cannot redirect; eret outranks a coincident flush upstream.
  always_comb begin
    take_int  = 1'b0;
    take_eret = 1'b0;
    case (state)
      ST_NORMAL, ST_INT_PEND: take_int  = req && !stall;
      ST_IN_HANDLER:          take_eret = eret && !stall;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc     <= 32'h0;
      int_ack <= 1'b0;
    end else begin
      int_ack <= take_int;
      if (take_int) epc <= IF_flush ? redirect_pc : pc;
    end
  end
endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register. Interrupt/eret support is
// built only when IF_INT_EN is defined; otherwise epc_o and int_ack_o are 0.
module if_id_stage
  import pcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input logic           clk,
  input logic           rst,
  if_id_stage_if.master bus
);
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] epc;
  logic        take_int;
  logic        take_eret;
  logic        bubble;

`ifdef IF_INT_EN
  if_int_ctrl u_int_ctrl (
    .clk         (clk),
    .rst         (rst),
    .stall       (bus.stall),
    .IF_flush    (bus.IF_flush),
    .redirect_pc (bus.redirect_pc_i),
    .int_req     (bus.int_req_i),
    .int_en      (bus.int_en_i),
    .eret        (bus.eret_i),
    .pc          (pc),
    .take_int    (take_int),
    .take_eret   (take_eret),
    .epc         (epc),
    .int_ack     (bus.int_ack_o),
    .state       (bus.int_state)
  );
  assign bus.epc_o = epc;
`else
  assign take_int      = 1'b0;
  assign take_eret     = 1'b0;
  assign epc           = 32'h0;
  assign bus.epc_o     = 32'h0;
  assign bus.int_ack_o = 1'b0;
  assign bus.int_state = ST_NORMAL;
`endif

  assign bubble          = take_int | take_eret | bus.IF_flush;
  assign bus.imem_addr_o = pc;

  always_comb begin
    if (take_int)          pc_next = HANDLER_PC;
    else if (take_eret)    pc_next = epc;
    else if (bus.IF_flush) pc_next = bus.redirect_pc_i;
    else if (bus.stall)    pc_next = pc;
    else                   pc_next = pc_plus4(pc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  // Any redirect discards the instruction fetched this cycle, even under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Instr_id_o <= BUBBLE_INSTR;
      bus.PC_id_o    <= 32'h0;
      bus.NPC_id_o   <= 32'h0;
      bus.Valid_id_o <= 1'b0;
    end else if (bubble) begin
      bus.Instr_id_o <= BUBBLE_INSTR;
      bus.PC_id_o    <= 32'h0;
      bus.NPC_id_o   <= 32'h0;
      bus.Valid_id_o <= 1'b0;
    end else if (!bus.stall) begin
      bus.Instr_id_o <= bus.imem_data_i;
      bus.PC_id_o    <= pc;
      bus.NPC_id_o   <= pc_plus4(pc);
      bus.Valid_id_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage; the reference model follows IF_INT_EN
// the same way the design does.
module tb_if_id_stage;
  localparam int W = 162;

  logic clk = 1'b0;
  logic rst = 1'b1;
  if_id_stage_if bus ();

  if_id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2001_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb bus.imem_data_i = mem(bus.imem_addr_o);

  // reference model
  logic [31:0] m_pc, m_instr, m_pcid, m_npcid, m_epc;
  logic        m_valid, m_ack;
  int          m_st;  // 0 normal, 1 pending, 2 in handler
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 0; m_pcid = 0; m_npcid = 0;
    m_epc = 0; m_valid = 0; m_ack = 0; m_st = 0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic [31:0] rp,
                            input logic rq, input logic en, input logic er);
    logic ti, te, req;
    logic [31:0] npc;
    ti = 1'b0; te = 1'b0; req = rq & en;
`ifdef IF_INT_EN
    ti = (m_st != 2) && req && !s;
    te = (m_st == 2) && er && !s;
`else
    req = 1'b0;
`endif
    if (ti) npc = 32'h0000_4180;
    else if (te) npc = m_epc;
    else if (f) npc = rp;
    else if (s) npc = m_pc;
    else npc = m_pc + 32'd4;
    if (ti || te || f) begin
      m_instr = 0; m_pcid = 0; m_npcid = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = mem(m_pc); m_pcid = m_pc; m_npcid = m_pc + 32'd4; m_valid = 1;
    end
    if (ti) m_epc = f ? rp : m_pc;
    m_ack = ti;
    if (ti) m_st = 2;
    else if (te) m_st = 0;
    else if (m_st == 0 && req && s) m_st = 1;
    else if (m_st == 1 && !req) m_st = 0;
    m_pc = npc;
  endtask

  function automatic logic [W-1:0] model_pack();
    return {m_pc, m_instr, m_pcid, m_npcid, m_epc, m_valid, m_ack};
  endfunction

  task automatic compare(input logic [W-1:0] e);
    check("imem_addr", bus.imem_addr_o, e[161:130]);
    check("instr_id",  bus.Instr_id_o,  e[129:98]);
    check("pc_id",     bus.PC_id_o,     e[97:66]);
    check("npc_id",    bus.NPC_id_o,    e[65:34]);
    check("epc",       bus.epc_o,       e[33:2]);
    check("valid_id",  {31'b0, bus.Valid_id_o}, {31'b0, e[1]});
    check("int_ack",   {31'b0, bus.int_ack_o},  {31'b0, e[0]});
  endtask

  task automatic step(input logic s, input logic f, input logic [31:0] rp,
                      input logic rq, input logic en, input logic er);
    bus.stall = s; bus.IF_flush = f; bus.redirect_pc_i = rp;
    bus.int_req_i = rq; bus.int_en_i = en; bus.eret_i = er;
    model_step(s, f, rp, rq, en, er);
    exp_q.push_back(model_pack());
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      compare(exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.stall = 0; bus.IF_flush = 0; bus.redirect_pc_i = 0;
    bus.int_req_i = 0; bus.int_en_i = 0; bus.eret_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(model_pack());
    rst = 1'b0;

    // straight-line fetch, then a 2-cycle stall, then resume
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    // flush coincident with stall
    step(1, 1, 32'h0000_3040, 0, 0, 0);
    idle(1);
    // interrupt at 0x3010, requests ignored in handler, eret back
    step(0, 1, 32'h0000_3010, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(2);
    // interrupt with flush to 0x3080; eret together with flush
    step(0, 1, 32'h0000_3080, 1, 1, 0);
    idle(1);
    step(0, 1, 32'h0000_3500, 0, 0, 1);
    idle(1);
    // interrupt raised under stall, taken on first unstalled edge
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1);  // stalled eret is not taken
    step(0, 0, 0, 0, 0, 1);
    // pending request withdrawn, then eret in NORMAL ignored
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // PC wraps at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    idle(2);
    // randomized mix
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           32'h0000_3000 + 32'($urandom_range(0, 63)) * 4,
           $urandom_range(0, 4) == 0, 1'b1, $urandom_range(0, 3) == 0);
    // reset while in the handler
    step(0, 0, 0, 1, 1, 0);
    idle(1);
    rst = 1'b1;
    #2;
    model_reset();
    compare(model_pack());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare(model_pack());
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
